alu_sched: RTL

Round-robin scheduler that shares one ALU instance between NREQ requesters. Each requester presents an operation (ALU_CTL, A, B) on a valid/ready handshake. The block latches the winning request, drives the external ALU for one cycle and captures Z/FLAGS. It returns the result, tagged with the requester ID, on a valid/ready response channel. It sits between the core's issue logic (and a debug/test port) and the ALU.

---
 rtl/alu_sched_pkg.sv | 33 +++
 rtl/alu_sched_rr_arbiter.sv | 38 +++
 rtl/alu_sched.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared types and constants for the ALU-sharing scheduler.
package alu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // ALU control encodings
    localparam logic [3:0] CTL_ADD  = 4'b0000;
    localparam logic [3:0] CTL_SUB  = 4'b0001;
    localparam logic [3:0] CTL_MUL  = 4'b0010;
    localparam logic [3:0] CTL_RSVD = 4'b0011;
    localparam logic [1:0] CTL_ROT_PFX   = 2'b01;
    localparam logic       CTL_LOGIC_PFX = 1'b1;

    // Flag bit positions in {Q,L,R,M,N,Z,C,V}
    localparam int FLG_Q = 7;
    localparam int FLG_L = 6;
    localparam int FLG_R = 5;
    localparam int FLG_M = 4;
    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    // Requester index width; never narrower than one bit
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// alu_sched_rr_arbiter: combinational round-robin pick of the first request
// at or after the pointer, wrapping around.
module alu_sched_rr_arbiter
    import alu_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int ID_W = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    int              j;
    logic [ID_W-1:0] jj;

    // Scan from the pointer upward; first hit wins
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            jj = ID_W'(j);
            if (!any && req[jj]) begin
                grant[jj] = 1'b1;
                idx       = jj;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: shares one external ALU between NREQ requesters in round-robin
// order. Optional feature macro: ALU_SCHED_ERRCNT_EN adds ERR_CNT, a
// saturating count of error/range-flagged responses.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int DATA_W = 8,
    parameter int CTL_W  = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NREQ-1:0]              REQ_VALID,
    output logic [NREQ-1:0]              REQ_READY,
    input  logic [NREQ*CTL_W-1:0]        REQ_CTL,
    input  logic [NREQ*DATA_W-1:0]       REQ_A,
    input  logic [NREQ*DATA_W-1:0]       REQ_B,
    output logic [CTL_W-1:0]             ALU_CTL,
    output logic [DATA_W-1:0]            ALU_A,
    output logic [DATA_W-1:0]            ALU_B,
    input  logic [DATA_W-1:0]            ALU_Z,
    input  logic [7:0]                   ALU_FLAGS,
    output logic                         RSP_VALID,
    input  logic                         RSP_READY,
    output logic [id_width(NREQ)-1:0]    RSP_ID,
    output logic [DATA_W-1:0]            RSP_Z,
    output logic [7:0]                   RSP_FLAGS,
    output logic                         RSP_ERR,
`ifdef ALU_SCHED_ERRCNT_EN
    output logic [7:0]                   ERR_CNT,
`endif
    output logic                         BUSY
);

    localparam int ID_W = id_width(NREQ);

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   next_ptr;
    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   gidx;
    logic              gany;
    logic [CTL_W-1:0]  sel_ctl;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    alu_sched_rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req   (REQ_VALID),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    assign REQ_READY = (state == IDLE) ? grant : '0;
    assign BUSY      = (state != IDLE);

    // Pick the winning payload and the pointer value that follows it
    always_comb begin
        sel_ctl = '0;
        sel_a   = '0;
        sel_b   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gidx == ID_W'(k)) begin
                sel_ctl = REQ_CTL[k*CTL_W +: CTL_W];
                sel_a   = REQ_A[k*DATA_W +: DATA_W];
                sel_b   = REQ_B[k*DATA_W +: DATA_W];
            end
        end
        if (int'(gidx) == NREQ - 1) next_ptr = '0;
        else                        next_ptr = gidx + 1'b1;
    end

    // Scheduler FSM; reserved ops bypass the ALU so ALU_CTL never carries them
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            ptr       <= '0;
            ALU_CTL   <= '0;
            ALU_A     <= '0;
            ALU_B     <= '0;
            RSP_VALID <= 1'b0;
            RSP_ID    <= '0;
            RSP_Z     <= '0;
            RSP_FLAGS <= '0;
            RSP_ERR   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gany) begin
                        ptr    <= next_ptr;
                        RSP_ID <= gidx;
                        if (sel_ctl == CTL_RSVD) begin
                            RSP_Z     <= '0;
                            RSP_FLAGS <= '0;
                            RSP_ERR   <= 1'b1;
                            RSP_VALID <= 1'b1;
                            state     <= RESP;
                        end else begin
                            ALU_CTL <= sel_ctl;
                            ALU_A   <= sel_a;
                            ALU_B   <= sel_b;
                            state   <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    RSP_Z     <= ALU_Z;
                    RSP_FLAGS <= ALU_FLAGS;
                    RSP_ERR   <= 1'b0;
                    RSP_VALID <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SCHED_ERRCNT_EN
    logic rsp_hs;
    logic err_hit;

    assign rsp_hs  = RSP_VALID & RSP_READY;
    assign err_hit = RSP_ERR | RSP_FLAGS[FLG_R] | RSP_FLAGS[FLG_M];

    // Saturating count of flagged responses at handoff
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ERR_CNT <= 8'h00;
        end else if (rsp_hs && err_hit && (ERR_CNT != 8'hFF)) begin
            ERR_CNT <= ERR_CNT + 8'd1;
        end
    end
`endif

endmodule
